ddr3_cpu_arb: RTL and testbench

Parametrised N-channel CPU-side front end for the DDR3 memory controller. Each channel gets its own request FIFO. A round-robin arbiter merges the channels onto the controller's single request port. Read data, which returns in order, is routed back to the issuing channel through an ordering FIFO. It sits between the CPU agents and the controller's CPU port and replaces the single-requester CPU connection.

---
 rtl/ddr3_cpu_arb.sv | 180 ++++++++++++++++++
 tb/tb_ddr3_cpu_arb.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_cpu_arb.sv
// N-channel round-robin front end onto the DDR3 controller CPU port; 1 cycle accept->mc_req_valid, 0 cycles read return.
// Backpressure: ch_req_ready drops when a channel FIFO is full; a stalled grant is held until mc_req_ready.

module ddr3_cpu_arb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       cpu_clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    output logic [W-1:0]               head_dat,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge cpu_clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    assign head_dat = mem[rd_ptr];
endmodule

module ddr3_cpu_arb #(
    parameter int NUM_CH     = 4,
    parameter int ADDR_W     = 27,
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_RD     = 8
) (
    input  logic                         cpu_clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            ch_req_valid,
    output logic [NUM_CH-1:0]            ch_req_ready,
    input  logic [NUM_CH-1:0]            ch_req_we,
    input  logic [NUM_CH*ADDR_W-1:0]     ch_req_addr,
    input  logic [NUM_CH*DATA_W-1:0]     ch_req_wdata,
    output logic [NUM_CH-1:0]            ch_rd_valid,
    output logic [DATA_W-1:0]            ch_rd_data,
    output logic                         mc_req_valid,
    input  logic                         mc_req_ready,
    output logic                         mc_req_we,
    output logic [ADDR_W-1:0]            mc_req_addr,
    output logic [DATA_W-1:0]            mc_req_wdata,
    input  logic                         mc_rd_valid,
    input  logic [DATA_W-1:0]            mc_rd_data,
    output logic [$clog2(MAX_RD+1)-1:0]  rd_outstanding,
    output logic                         rd_err
);
    localparam int ID_W = $clog2(NUM_CH);
    localparam int FC_W = $clog2(FIFO_DEPTH+1);
    localparam int OC_W = $clog2(MAX_RD+1);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    req_t              head [NUM_CH];
    logic [FC_W-1:0]   fcnt [NUM_CH];
    logic [NUM_CH-1:0] ch_push;
    logic [NUM_CH-1:0] ch_pop;
    logic [NUM_CH-1:0] eligible;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   rr_grant;
    logic [ID_W-1:0]   grant;
    logic [ID_W-1:0]   lock_id;
    logic              lock;
    logic              found;
    logic              hs;
    logic              rd_room;
    logic              ord_push;
    logic              ord_pop;
    logic              ord_empty;
    logic [ID_W-1:0]   ord_id;
    req_t              gnt_req;

    // Eligibility reads only the registered count, keeping mc_rd_valid off the request path.
    assign rd_room = rd_outstanding < OC_W'(MAX_RD);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        req_t in_req;
        assign in_req          = {ch_req_we[i], ch_req_addr[i*ADDR_W +: ADDR_W], ch_req_wdata[i*DATA_W +: DATA_W]};
        assign ch_req_ready[i] = rst_n & (fcnt[i] != FC_W'(FIFO_DEPTH));
        assign ch_push[i]      = ch_req_valid[i] & ch_req_ready[i];
        assign ch_pop[i]       = hs & (grant == ID_W'(i));
        assign eligible[i]     = (fcnt[i] != '0) & (head[i].we | rd_room);

        ddr3_cpu_arb_fifo #(.W($bits(req_t)), .DEPTH(FIFO_DEPTH)) u_req_fifo (
            .cpu_clk  (cpu_clk),
            .rst_n    (rst_n),
            .push     (ch_push[i]),
            .push_dat (in_req),
            .pop      (ch_pop[i]),
            .head_dat (head[i]),
            .count    (fcnt[i])
        );
    end

    always_comb begin
        logic [ID_W:0]   sum;
        logic [ID_W-1:0] idx;
        rr_grant = rr_ptr;
        found    = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NUM_CH)) sum = sum - (ID_W+1)'(NUM_CH);
            idx = sum[ID_W-1:0];
            if (!found && eligible[idx]) begin
                found    = 1'b1;
                rr_grant = idx;
            end
        end
    end

    assign grant        = lock ? lock_id : rr_grant;
    assign mc_req_valid = |eligible;
    assign gnt_req      = head[grant];
    assign mc_req_we    = gnt_req.we;
    assign mc_req_addr  = gnt_req.addr;
    assign mc_req_wdata = gnt_req.wdata;
    assign hs           = mc_req_valid & mc_req_ready;

    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= '0;
            lock    <= 1'b0;
            lock_id <= '0;
            rd_err  <= 1'b0;
        end else begin
            if (hs) begin
                rr_ptr <= (grant == ID_W'(NUM_CH-1)) ? '0 : grant + 1'b1;
                lock   <= 1'b0;
            end else if (mc_req_valid) begin
                lock    <= 1'b1;
                lock_id <= grant;
            end
            if (mc_rd_valid && ord_empty) rd_err <= 1'b1;
        end
    end

    // Ordering FIFO holds the channel ID of each issued read, in issue order.
    assign ord_empty = (rd_outstanding == '0);
    assign ord_push  = hs & ~mc_req_we;
    assign ord_pop   = mc_rd_valid & ~ord_empty;

    ddr3_cpu_arb_fifo #(.W(ID_W), .DEPTH(MAX_RD)) u_ord_fifo (
        .cpu_clk  (cpu_clk),
        .rst_n    (rst_n),
        .push     (ord_push),
        .push_dat (grant),
        .pop      (ord_pop),
        .head_dat (ord_id),
        .count    (rd_outstanding)
    );

    assign ch_rd_valid = ord_pop ? ({{(NUM_CH-1){1'b0}}, 1'b1} << ord_id) : '0;
    assign ch_rd_data  = mc_rd_data;
endmodule

// File: tb/tb_ddr3_cpu_arb.sv
// Scoreboard bench for ddr3_cpu_arb: stimulus queues expected controller requests and read returns, a negedge monitor checks them.
module tb_ddr3_cpu_arb;
    localparam int NUM_CH = 4;
    localparam int ADDR_W = 27;
    localparam int DATA_W = 64;

    logic                     cpu_clk = 1'b0;
    logic                     rst_n;
    logic [NUM_CH-1:0]        ch_req_valid;
    logic [NUM_CH-1:0]        ch_req_ready;
    logic [NUM_CH-1:0]        ch_req_we;
    logic [NUM_CH*ADDR_W-1:0] ch_req_addr;
    logic [NUM_CH*DATA_W-1:0] ch_req_wdata;
    logic [NUM_CH-1:0]        ch_rd_valid;
    logic [DATA_W-1:0]        ch_rd_data;
    logic                     mc_req_valid;
    logic                     mc_req_ready;
    logic                     mc_req_we;
    logic [ADDR_W-1:0]        mc_req_addr;
    logic [DATA_W-1:0]        mc_req_wdata;
    logic                     mc_rd_valid;
    logic [DATA_W-1:0]        mc_rd_data;
    logic [3:0]               rd_outstanding;
    logic                     rd_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [91:0] exp_req [$];
    logic [67:0] exp_rd  [$];

    ddr3_cpu_arb dut (
        .cpu_clk        (cpu_clk),
        .rst_n          (rst_n),
        .ch_req_valid   (ch_req_valid),
        .ch_req_ready   (ch_req_ready),
        .ch_req_we      (ch_req_we),
        .ch_req_addr    (ch_req_addr),
        .ch_req_wdata   (ch_req_wdata),
        .ch_rd_valid    (ch_rd_valid),
        .ch_rd_data     (ch_rd_data),
        .mc_req_valid   (mc_req_valid),
        .mc_req_ready   (mc_req_ready),
        .mc_req_we      (mc_req_we),
        .mc_req_addr    (mc_req_addr),
        .mc_req_wdata   (mc_req_wdata),
        .mc_rd_valid    (mc_rd_valid),
        .mc_rd_data     (mc_rd_data),
        .rd_outstanding (rd_outstanding),
        .rd_err         (rd_err)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic send(input int ch, input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wd, input logic expect_issue);
        ch_req_valid[ch]                  = 1'b1;
        ch_req_we[ch]                     = we;
        ch_req_addr[ch*ADDR_W +: ADDR_W]  = addr;
        ch_req_wdata[ch*DATA_W +: DATA_W] = wd;
        if (expect_issue) exp_req.push_back({we, addr, wd});
        tick();
        ch_req_valid[ch] = 1'b0;
    endtask

    task automatic ret(input logic [DATA_W-1:0] d, input logic [NUM_CH-1:0] oh);
        mc_rd_valid = 1'b1;
        mc_rd_data  = d;
        exp_rd.push_back({oh, d});
        tick();
        mc_rd_valid = 1'b0;
    endtask

    // Monitor: every controller handshake and every read strobe must match the queue head.
    always @(negedge cpu_clk) begin
        if (rst_n && mc_req_valid && mc_req_ready) begin
            if (exp_req.size() == 0) begin
                total_cnt++;
                $display("FAIL req_unexpected: got we=%0b addr=0x%0h, expected no request", mc_req_we, mc_req_addr);
            end else begin
                chk("req", {mc_req_we, mc_req_addr, mc_req_wdata}, exp_req.pop_front());
            end
        end
        if (ch_rd_valid != '0) begin
            if (exp_rd.size() == 0) begin
                total_cnt++;
                $display("FAIL rd_unexpected: got strobe=%b data=0x%0h, expected no strobe", ch_rd_valid, ch_rd_data);
            end else begin
                chk("rd_return", {ch_rd_valid, ch_rd_data}, exp_rd.pop_front());
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        ch_req_valid = '0;
        ch_req_we    = '0;
        ch_req_addr  = '0;
        ch_req_wdata = '0;
        mc_req_ready = 1'b0;
        mc_rd_valid  = 1'b0;
        mc_rd_data   = '0;
        #2;
        chk("rst_ready",  ch_req_ready, 4'h0);
        chk("rst_valid",  mc_req_valid, 1'b0);
        chk("rst_rdv",    ch_rd_valid, 4'h0);
        chk("rst_out",    rd_outstanding, 4'd0);
        chk("rst_err",    rd_err, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", ch_req_ready, 4'hF);
        mc_req_ready = 1'b1;

        // Single channel: write then read, then a same-cycle return.
        chk("empty_no_valid", mc_req_valid, 1'b0);
        send(0, 1'b1, 27'h100, 64'h1111, 1'b1);
        chk("accept_latency", mc_req_valid, 1'b1);
        send(0, 1'b0, 27'h100, 64'h0, 1'b1);
        tick();
        chk("single_out", rd_outstanding, 4'd1);
        chk("single_idle", mc_req_valid, 1'b0);
        ret(64'hDEAD, 4'b0001);
        chk("single_drained", rd_outstanding, 4'd0);

        // Fairness: fill every FIFO with writes while stalled; rr_ptr is now 1.
        mc_req_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                ch_req_valid[c]                  = 1'b1;
                ch_req_we[c]                     = 1'b1;
                ch_req_addr[c*ADDR_W +: ADDR_W]  = ADDR_W'(32'h1000 + c*16 + k);
                ch_req_wdata[c*DATA_W +: DATA_W] = DATA_W'(32'hC000 + c*16 + k);
            end
            tick();
        end
        ch_req_valid = '0;
        chk("all_full", ch_req_ready, 4'h0);
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < NUM_CH; j++)
                exp_req.push_back({1'b1, ADDR_W'(32'h1000 + ((j+1)%4)*16 + r), DATA_W'(32'hC000 + ((j+1)%4)*16 + r)});
        mc_req_ready = 1'b1;
        repeat (17) tick();
        chk("fair_drained", mc_req_valid, 1'b0);

        // Move rr_ptr to 0 so that ch0 would win a fresh arbitration.
        send(3, 1'b1, 27'h3300, 64'h3333, 1'b1);
        tick();

        // Lock: ch2 stalled for 5 cycles, ch0 arrives mid-stall.
        mc_req_ready = 1'b0;
        send(2, 1'b1, 27'h2220, 64'h2222, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("lock_hold", {mc_req_valid, mc_req_we, mc_req_addr, mc_req_wdata}, {1'b1, 1'b1, 27'h2220, 64'h2222});
            if (i == 1) send(0, 1'b1, 27'h2000, 64'h2002, 1'b1);
            else tick();
        end
        mc_req_ready = 1'b1;
        repeat (3) tick();

        // Read limit: nine reads from ch1, no returns.
        for (int k = 0; k < 9; k++)
            send(1, 1'b0, ADDR_W'(32'h4000 + k), 64'h0, k < 8);
        repeat (3) tick();
        chk("limit_stall", mc_req_valid, 1'b0);
        chk("limit_count", rd_outstanding, 4'd8);
        send(2, 1'b1, 27'h4200, 64'h4242, 1'b1);
        chk("limit_write", {mc_req_valid, mc_req_addr}, {1'b1, 27'h4200});
        tick();
        chk("limit_stall2", mc_req_valid, 1'b0);
        exp_req.push_back({1'b0, 27'h4008, 64'h0});
        ret(64'hAAA0, 4'b0010);
        chk("limit_release", {mc_req_valid, mc_req_addr}, {1'b1, 27'h4008});
        ret(64'hAAA1, 4'b0010);
        chk("hs_and_return", rd_outstanding, 4'd7);
        for (int i = 0; i < 7; i++) ret(DATA_W'(32'hB000 + i), 4'b0010);
        chk("limit_drained", rd_outstanding, 4'd0);

        // Ordering across channels.
        send(3, 1'b0, 27'h5300, 64'h0, 1'b1);
        send(1, 1'b0, 27'h5100, 64'h0, 1'b1);
        send(3, 1'b0, 27'h5301, 64'h0, 1'b1);
        tick();
        tick();
        chk("order_out", rd_outstanding, 4'd3);
        ret(64'hD0, 4'b1000);
        ret(64'hD1, 4'b0010);
        ret(64'hD2, 4'b1000);
        chk("order_drained", rd_outstanding, 4'd0);

        // Reset with reads outstanding and FIFOs occupied, then a stale return.
        for (int i = 0; i < 3; i++) send(0, 1'b0, ADDR_W'(32'h6000 + i), 64'h0, 1'b1);
        tick();
        tick();
        chk("pre_rst_out", rd_outstanding, 4'd3);
        mc_req_ready = 1'b0;
        send(1, 1'b1, 27'h6100, 64'h61, 1'b0);
        send(2, 1'b1, 27'h6200, 64'h62, 1'b0);
        chk("pre_rst_valid", mc_req_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out", rd_outstanding, 4'd0);
        chk("mid_rst_valid", mc_req_valid, 1'b0);
        chk("mid_rst_ready", ch_req_ready, 4'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", ch_req_ready, 4'hF);
        chk("post_rst_valid", mc_req_valid, 1'b0);
        chk("post_rst_err", rd_err, 1'b0);
        mc_rd_valid = 1'b1;
        mc_rd_data  = 64'hBAD;
        #1;
        chk("stale_no_strobe", ch_rd_valid, 4'h0);
        tick();
        mc_rd_valid = 1'b0;
        chk("stale_err", rd_err, 1'b1);
        tick();
        chk("err_sticky", rd_err, 1'b1);

        chk("req_queue_empty", 32'(exp_req.size()), 32'd0);
        chk("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
